boot_loader: RTL

BOOT_LOADER -- requirements
Module: boot_loader

---
 rtl/boot_loader_pkg.sv | 30 +++
 rtl/boot_loader_if.sv | 22 ++
 rtl/boot_loader_tmr.sv | 33 +++
 rtl/boot_loader.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/boot_loader_pkg.sv
// Shared types and defaults for the serial boot loader.
package boot_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_CNT_HI = 4'd1,
    ST_CNT_LO = 4'd2,
    ST_DAT_HI = 4'd3,
    ST_DAT_LO = 4'd4,
    ST_WRITE  = 4'd5,
    ST_CHK    = 4'd6,
    ST_DONE   = 4'd7,
    ST_ERR    = 4'd8
  } boot_state_e;

  localparam logic [7:0]  SYNC_BYTE_DEF   = 8'hA5;
  localparam int unsigned MAX_WORDS_DEF   = 16384;
  localparam int unsigned TIMEOUT_CYC_DEF = 1000000;

  // States that belong to an open frame, where the inter-byte timer runs.
  function automatic logic in_frame(input boot_state_e st);
    logic r;
    case (st)
      ST_CNT_HI, ST_CNT_LO, ST_DAT_HI, ST_DAT_LO, ST_WRITE, ST_CHK: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/boot_loader_if.sv
// UART-receive and instruction-memory-write bundle of the boot loader.
interface boot_loader_if;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rdy;
  logic        debug;
  logic [15:0] in_addr;
  logic [15:0] wr_instr;
  logic        boot_busy;
  logic        boot_done;
  logic        boot_err;

  modport master (
    input  rx_rdy, rx_data,
    output clr_rdy, debug, in_addr, wr_instr, boot_busy, boot_done, boot_err
  );

  modport slave (
    output rx_rdy, rx_data,
    input  clr_rdy, debug, in_addr, wr_instr, boot_busy, boot_done, boot_err
  );
endinterface

// File: rtl/boot_loader_tmr.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and
// saturates at TIMEOUT_CYC, flagging expiry.
module boot_tmr #(
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYC);

  logic [W-1:0] cnt_q;

  // Cycle counter with clear priority and saturation at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (enable_i && (cnt_q != LIMIT)) begin
      cnt_q <= cnt_q + W'(1);
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/boot_loader.sv
// Serial boot loader: receives a framed program image byte by byte and
// writes it word by word into instruction memory.
module boot_loader
  import boot_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter int unsigned MAX_WORDS   = MAX_WORDS_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input logic          clk,
  input logic          rst_n,
  boot_loader_if.master bus
);

  localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

  boot_state_e state_q;
  logic        clr_rdy_q;
  logic        debug_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic [15:0] in_addr_q;
  logic [15:0] wr_instr_q;
  logic [15:0] hold_q;
  logic [15:0] addr_cnt_q;
  logic [15:0] remain_q;
  logic [7:0]  cnt_hi_q;
  logic [7:0]  chk_q;

  logic        consume_s;
  logic        expired_s;
  logic [15:0] count_s;
  logic        too_many_s;

  // WRITE never takes a byte so the incoming one waits for DAT_HI/CHK.
  assign consume_s  = bus.rx_rdy & ~clr_rdy_q & (state_q != ST_WRITE);
  assign count_s    = {cnt_hi_q, bus.rx_data};
  assign too_many_s = ({1'b0, count_s} > MAX_W);

  boot_tmr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (consume_s),
    .enable_i (in_frame(state_q)),
    .expired_o(expired_s)
  );

  // Frame FSM; the checksum covers the payload bytes only, count bytes excluded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      clr_rdy_q  <= 1'b0;
      debug_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      in_addr_q  <= 16'h0000;
      wr_instr_q <= 16'h0000;
      hold_q     <= 16'h0000;
      addr_cnt_q <= 16'h0000;
      remain_q   <= 16'h0000;
      cnt_hi_q   <= 8'h00;
      chk_q      <= 8'h00;
    end else begin
      clr_rdy_q <= consume_s;
      debug_q   <= 1'b0;
      if (in_frame(state_q) && (state_q != ST_WRITE) && !consume_s && expired_s) begin
        state_q <= ST_ERR;
        err_q   <= 1'b1;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE, ST_DONE, ST_ERR: begin
            if (consume_s && (bus.rx_data == SYNC_BYTE)) begin
              state_q    <= ST_CNT_HI;
              done_q     <= 1'b0;
              err_q      <= 1'b0;
              busy_q     <= 1'b1;
              chk_q      <= 8'h00;
              addr_cnt_q <= 16'h0000;
            end else begin
              state_q <= state_q;
            end
          end
          ST_CNT_HI: begin
            if (consume_s) begin
              cnt_hi_q <= bus.rx_data;
              state_q  <= ST_CNT_LO;
            end else begin
              state_q <= state_q;
            end
          end
          ST_CNT_LO: begin
            if (consume_s) begin
              remain_q <= count_s;
              if (count_s == 16'h0000) begin
                state_q <= ST_CHK;
              end else if (too_many_s) begin
                state_q <= ST_ERR;
                err_q   <= 1'b1;
                busy_q  <= 1'b0;
              end else begin
                state_q <= ST_DAT_HI;
              end
            end else begin
              state_q <= state_q;
            end
          end
          ST_DAT_HI: begin
            if (consume_s) begin
              hold_q[15:8] <= bus.rx_data;
              chk_q        <= chk_q ^ bus.rx_data;
              state_q      <= ST_DAT_LO;
            end else begin
              state_q <= state_q;
            end
          end
          ST_DAT_LO: begin
            if (consume_s) begin
              hold_q[7:0] <= bus.rx_data;
              chk_q       <= chk_q ^ bus.rx_data;
              wr_instr_q  <= {hold_q[15:8], bus.rx_data};
              in_addr_q   <= addr_cnt_q;
              debug_q     <= 1'b1;
              state_q     <= ST_WRITE;
            end else begin
              state_q <= state_q;
            end
          end
          ST_WRITE: begin
            addr_cnt_q <= addr_cnt_q + 16'd1;
            remain_q   <= remain_q - 16'd1;
            if (remain_q == 16'd1) begin
              state_q <= ST_CHK;
            end else begin
              state_q <= ST_DAT_HI;
            end
          end
          ST_CHK: begin
            if (consume_s) begin
              busy_q <= 1'b0;
              if (bus.rx_data == chk_q) begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= ST_ERR;
                err_q   <= 1'b1;
              end
            end else begin
              state_q <= state_q;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.clr_rdy   = clr_rdy_q;
  assign bus.debug     = debug_q;
  assign bus.in_addr   = in_addr_q;
  assign bus.wr_instr  = wr_instr_q;
  assign bus.boot_busy = busy_q;
  assign bus.boot_done = done_q;
  assign bus.boot_err  = err_q;

endmodule
